rif_arbiter: RTL and testbench
==============================

# rif_arbiter

- Shares one RIF register-file port between `NUM_REQ` requesters, e.g. several AXI-Lite adapters or an AXI-Lite adapter plus an internal sequencer.
- Grants one request per cycle by round-robin and issues it to the RIF through a registered stage.
- Returns the RIF access result (read data, error) to the originating requester a fixed two cycles after grant.
- Sits between the requesters and the RIF slave; the RIF side uses the same single-cycle req/valid RIF protocol the AXI-Lite adapter drives.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requester ports (≥2).
- `ADDR_WIDTH`, 12, RIF address width.
- `DATA_WIDTH`, 32, RIF data width.
- `BYTE_COUNT`, `DATA_WIDTH/8`, strobe width.

Ports:
- Clocking: one clock, `aclk`. Reset `aresetn` is asynchronous, active-low.
- `aclk`  in  1  clock
- `aresetn`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_REQ  per-requester access request
- `req_ready`  out  NUM_REQ  grant; handshake when valid&ready
- `req_write`  in  NUM_REQ  1=write, 0=read
- `req_addr`  in  NUM_REQ×ADDR_WIDTH  access address
- `req_wdata`  in  NUM_REQ×DATA_WIDTH  write data
- `req_wstrb`  in  NUM_REQ×BYTE_COUNT  write strobes
- `rsp_valid`  out  NUM_REQ  one-cycle response pulse
- `rsp_rdata`  out  DATA_WIDTH  read data (shared, qualified by `rsp_valid`)
- `rsp_err`  out  1  access error (shared, qualified by `rsp_valid`)
- `rif_waddr`, `rif_wdata`, `rif_wstrb`, `rif_wr_req`  out  ADDR_WIDTH/DATA_WIDTH/BYTE_COUNT/1  RIF write channel
- `rif_wvalid`  in  1  RIF write accepted (same cycle as `rif_wr_req`)
- `rif_raddr`, `rif_rd_req`  out  ADDR_WIDTH/1  RIF read channel
- `rif_rvalid`, `rif_rdata`  in  1/DATA_WIDTH  RIF read accepted and data (same cycle as `rif_rd_req`)

## Operation
- **Arbitration (combinational):** `req_ready` is one-hot or zero. Search starts at round-robin pointer `ptr` and wraps modulo `NUM_REQ`. The first `req_valid` found is granted.
- **Pointer update:** on a handshake at index i, `ptr` ← (i+1) mod NUM_REQ. With no handshake, `ptr` holds. `ptr` resets to 0.
- **Issue stage:** registered; holds valid, write, addr, wdata, wstrb and the requester index. It is loaded on every handshake and cleared otherwise.
  - Issue valid & write: `rif_wr_req`=1.
  - Issue valid & read: `rif_rd_req`=1.
  - `rif_wr_req` and `rif_rd_req` are never both high.
- **RIF address/data outputs:** `rif_waddr`/`rif_raddr` both mirror the issue address. `rif_wdata` mirrors issue data. `rif_wstrb` is issue strobes when `rif_wr_req`=1, else 0.
- **Response stage:** registered; captured at the end of each issue cycle.
  - `rsp_valid[idx]`=1 for that one cycle.
  - Reads: `rsp_rdata`=`rif_rdata`, `rsp_err`=~`rif_rvalid`.
  - Writes: `rsp_rdata`=0, `rsp_err`=~`rif_wvalid`.
- **No response backpressure:** requesters must accept `rsp_valid`. The RIF is single-cycle, so the pipeline never stalls.
- **Requester rule:** once `req_valid` is high, it and its payload stay stable until `req_ready`. The bench asserts this; the RTL does not check it.
- A requester may issue back-to-back requests. It receives responses in order.

## Timing
- **Reset values:** all outputs 0 (`req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, all `rif_*`); `ptr`=0; both stages invalid. Async assert, sync deassert at the system level.
- **Latency:** handshake in cycle T → RIF request in T+1 → `rsp_valid` in T+2.
- **Throughput:** one access per cycle in aggregate.
- **Fairness:** with all requesters valid continuously, grants rotate 0,1,…,N-1,0. No requester waits more than NUM_REQ-1 cycles once valid.
- **Reset mid-operation:** in-flight issue and response stages are discarded; no `rsp_valid` follows reset.
- **Same-requester pipelining:** a single requester holding `req_valid` is granted every cycle when the others are idle.

## Structure
- **Shared package `rif_pkg`:**
  - `rif_req_t` struct: write, addr, wdata, wstrb.
  - `rif_rsp_t` struct: rdata, err.
  - `RIF_ERR` constant.
- **Sub-module `rr_arbiter`:** parameter `N`; inputs `req[N]` and `advance`; output one-hot `gnt[N]`; owns `ptr`. It is reusable elsewhere.
- **Top level:** instantiates `rr_arbiter` and the two pipeline registers.

## Test plan
- **Single read:** requester 0 reads addr 0x010, slave returns `rif_rvalid`=1, data 0xDEADBEEF → `rif_rd_req` at T+1 with `rif_raddr`=0x010; `rsp_valid[0]` at T+2 with `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- **Write error:** requester 1 writes 0x020, data 0x12345678, strb 0xF, slave `rif_wvalid`=0 → `rif_wstrb`=0xF at T+1; `rsp_valid[1]`, `rsp_err`=1, `rsp_rdata`=0 at T+2.
- **Contention, NUM_REQ=2:** both requesters held valid for 6 cycles → grants 0,1,0,1,0,1; responses follow with the same order and 2-cycle latency.
- **Pointer update:** only requester 1 valid for 3 cycles, then both valid → requester 0 granted first (`ptr`=0 after granting 1).
- **Reset mid-flight:** `aresetn` low during the issue cycle → `rif_*` and `rsp_valid` go 0 immediately; after release, first grant goes to requester 0.
- **Payload stability:** a requester changes `req_addr` while valid and not ready → the bench assertion fires (negative test).

Source files
------------

// File: rtl/rif_pkg.sv
// Shared RIF definitions: default widths, request/response records and the
// error encoding used when the register file does not accept an access.
package rif_pkg;

    localparam int RIF_ADDR_W = 12;
    localparam int RIF_DATA_W = 32;
    localparam int RIF_BYTE_W = RIF_DATA_W / 8;

    // Value of the response error flag when an access was rejected
    localparam logic RIF_ERR = 1'b1;

    typedef struct packed {
        logic                  write;
        logic [RIF_ADDR_W-1:0] addr;
        logic [RIF_DATA_W-1:0] wdata;
        logic [RIF_BYTE_W-1:0] wstrb;
    } rif_req_t;

    typedef struct packed {
        logic [RIF_DATA_W-1:0] rdata;
        logic                  err;
    } rif_rsp_t;

    // Error flag for an access, given whether the RIF accepted it
    function automatic logic rif_err_of(input logic accepted);
        return accepted ? ~RIF_ERR : RIF_ERR;
    endfunction

endpackage

// File: rtl/rif_arbiter_if.sv
// Bundle of requester-side and RIF-side signals around the arbiter.
// The slave view is the arbiter; the master view is its environment
// (requesters plus the RIF register file).
interface rif_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_COUNT = DATA_WIDTH / 8
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 req_write;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0][BYTE_COUNT-1:0] req_wstrb;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [DATA_WIDTH-1:0]              rsp_rdata;
    logic                               rsp_err;

    logic [ADDR_WIDTH-1:0]              rif_waddr;
    logic [DATA_WIDTH-1:0]              rif_wdata;
    logic [BYTE_COUNT-1:0]              rif_wstrb;
    logic                               rif_wr_req;
    logic                               rif_wvalid;
    logic [ADDR_WIDTH-1:0]              rif_raddr;
    logic                               rif_rd_req;
    logic                               rif_rvalid;
    logic [DATA_WIDTH-1:0]              rif_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output rif_waddr, rif_wdata, rif_wstrb, rif_wr_req, rif_raddr, rif_rd_req,
        input  rif_wvalid, rif_rvalid, rif_rdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  rif_waddr, rif_wdata, rif_wstrb, rif_wr_req, rif_raddr, rif_rd_req,
        output rif_wvalid, rif_rvalid, rif_rdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searched from a rotating
// pointer; the pointer moves past the winner whenever the grant is taken.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Scan requesters starting at ptr, wrapping, and grant the first active one
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        cand    = ptr;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found      = 1'b1;
                gnt_idx    = cand;
                gnt[cand]  = 1'b1;
            end
        end
    end

    // Move the pointer one past the requester that was served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rif_arbiter.sv
// Shares one RIF port between NUM_REQ requesters. Grant is combinational,
// the winning access is registered into an issue stage that drives the RIF,
// and the RIF result is registered into a response stage routed back to the
// originating requester two cycles after its handshake.
module rif_arbiter
    import rif_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = RIF_ADDR_W,
    parameter int DATA_WIDTH = RIF_DATA_W,
    parameter int BYTE_COUNT = DATA_WIDTH / 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    rif_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    ready;
    logic                  hs;

    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BYTE_COUNT-1:0] sel_wstrb;
    logic [IDX_W-1:0]      sel_idx;

    logic                  vld_p1;
    logic                  wr_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;
    logic [BYTE_COUNT-1:0] wstrb_p1;
    logic [IDX_W-1:0]      idx_p1;

    logic [NUM_REQ-1:0]    vld_p2;
    logic [DATA_WIDTH-1:0] rdata_p2;
    logic                  err_p2;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (aclk),
        .rst_n   (aresetn),
        .req     (bus.req_valid),
        .advance (hs),
        .gnt     (gnt)
    );

    // ---- stage p0: grant and payload select ----
    // Grants are suppressed while reset is asserted so no handshake can form
    assign ready         = gnt & {NUM_REQ{aresetn}};
    assign hs            = |(ready & bus.req_valid);
    assign bus.req_ready = ready;

    // Route the granted requester's payload toward the issue stage
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready[i]) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[i];
                sel_wdata = bus.req_wdata[i];
                sel_wstrb = bus.req_wstrb[i];
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // ---- stage p1: issue register, drives the RIF ----
    // Loaded on every handshake, cleared on idle cycles so RIF outputs rest at 0
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1   <= 1'b0;
            wr_p1    <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            wstrb_p1 <= '0;
            idx_p1   <= '0;
        end else if (hs) begin
            vld_p1   <= 1'b1;
            wr_p1    <= sel_write;
            addr_p1  <= sel_addr;
            wdata_p1 <= sel_wdata;
            wstrb_p1 <= sel_wstrb;
            idx_p1   <= sel_idx;
        end else begin
            vld_p1   <= 1'b0;
            wr_p1    <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            wstrb_p1 <= '0;
            idx_p1   <= '0;
        end
    end

    assign bus.rif_wr_req = vld_p1 & wr_p1;
    assign bus.rif_rd_req = vld_p1 & ~wr_p1;
    assign bus.rif_waddr  = addr_p1;
    assign bus.rif_raddr  = addr_p1;
    assign bus.rif_wdata  = wdata_p1;
    assign bus.rif_wstrb  = bus.rif_wr_req ? wstrb_p1 : '0;

    // ---- stage p2: response register, back to the requester ----
    // Capture the single-cycle RIF result at the end of each issue cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p2   <= '0;
            rdata_p2 <= '0;
            err_p2   <= 1'b0;
        end else if (vld_p1) begin
            vld_p2   <= NUM_REQ'(1) << idx_p1;
            rdata_p2 <= wr_p1 ? '0 : bus.rif_rdata;
            err_p2   <= wr_p1 ? rif_err_of(bus.rif_wvalid) : rif_err_of(bus.rif_rvalid);
        end else begin
            vld_p2   <= '0;
            rdata_p2 <= '0;
            err_p2   <= 1'b0;
        end
    end

    assign bus.rsp_valid = vld_p2;
    assign bus.rsp_rdata = rdata_p2;
    assign bus.rsp_err   = err_p2;

endmodule

// File: tb/tb_rif_arbiter.sv
// Bench for rif_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model of the arbiter.
module tb_rif_arbiter;
    import rif_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = RIF_ADDR_W;
    localparam int DW   = RIF_DATA_W;
    localparam int BW   = RIF_BYTE_W;

    logic aclk;
    logic aresetn;
    int   checks   = 0;
    int   failures = 0;

    rif_arbiter_if #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_COUNT(BW)) bus ();

    rif_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_COUNT(BW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- reference model ----------------
    // Next winner: first valid requester after the last one served, cyclically
    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    int              m_last;
    int              m_g;
    logic [NREQ-1:0] m_ready;
    logic            m_iss_v;
    rif_req_t        m_iss;
    int              m_iss_idx;
    logic [NREQ-1:0] m_rsp_v;
    rif_rsp_t        m_rsp;

    always_comb begin
        m_ready = '0;
        m_g     = pick(bus.req_valid, m_last);
        if (aresetn && m_g >= 0) m_ready[m_g] = 1'b1;
    end

    // Accepted request appears on the RIF next cycle, its result one cycle later
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_last    <= NREQ - 1;
            m_iss_v   <= 1'b0;
            m_iss     <= '0;
            m_iss_idx <= 0;
            m_rsp_v   <= '0;
            m_rsp     <= '0;
        end else begin
            if (m_g >= 0) begin
                m_last      <= m_g;
                m_iss_v     <= 1'b1;
                m_iss.write <= bus.req_write[m_g];
                m_iss.addr  <= bus.req_addr[m_g];
                m_iss.wdata <= bus.req_wdata[m_g];
                m_iss.wstrb <= bus.req_wstrb[m_g];
                m_iss_idx   <= m_g;
            end else begin
                m_iss_v <= 1'b0;
                m_iss   <= '0;
            end
            m_rsp_v <= '0;
            if (m_iss_v) begin
                m_rsp_v[m_iss_idx] <= 1'b1;
                m_rsp.rdata <= m_iss.write ? '0 : bus.rif_rdata;
                m_rsp.err   <= m_iss.write ? !bus.rif_wvalid : !bus.rif_rvalid;
            end else begin
                m_rsp <= '0;
            end
        end
    end

    // ---------------- requester-rule monitor ----------------
    // A pending request (valid, not ready) must keep valid and payload next cycle
    logic [NREQ-1:0]         pend_prev;
    logic [NREQ-1:0]         pw_prev;
    logic [NREQ-1:0][AW-1:0] pa_prev;
    logic [NREQ-1:0][DW-1:0] pd_prev;
    logic [NREQ-1:0][BW-1:0] ps_prev;
    int                      stab_viol = 0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend_prev <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend_prev[i] && (!bus.req_valid[i] || bus.req_write[i] != pw_prev[i] ||
                    bus.req_addr[i] != pa_prev[i] || bus.req_wdata[i] != pd_prev[i] ||
                    bus.req_wstrb[i] != ps_prev[i]))
                    stab_viol <= stab_viol + 1;
            end
            pend_prev <= bus.req_valid & ~bus.req_ready;
            pw_prev   <= bus.req_write;
            pa_prev   <= bus.req_addr;
            pd_prev   <= bus.req_wdata;
            ps_prev   <= bus.req_wstrb;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset;
        bus.req_valid = '1;
        #3;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rif_wr_req, bus.rif_rd_req} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b rsp_valid=%b err=%b wr=%b rd=%b, expected all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rif_wr_req, bus.rif_rd_req);
        end
        checks++;
        if ({bus.rsp_rdata, bus.rif_waddr, bus.rif_raddr, bus.rif_wdata, bus.rif_wstrb} !== '0) begin
            failures++;
            $display("FAIL reset_data: rdata=%h waddr=%h raddr=%h wdata=%h wstrb=%h, expected all 0",
                     bus.rsp_rdata, bus.rif_waddr, bus.rif_raddr, bus.rif_wdata, bus.rif_wstrb);
        end
        bus.req_valid = '0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_single_read;
        @(posedge aclk); #1;
        bus.req_valid    = 2'b01;
        bus.req_write[0] = 1'b0;
        bus.req_addr[0]  = 12'h010;
        bus.rif_rvalid   = 1'b1;
        bus.rif_wvalid   = 1'b1;
        bus.rif_rdata    = 32'hDEADBEEF;
        @(negedge aclk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++; $display("FAIL rd_grant: ready=%b expected 01", bus.req_ready);
        end
        @(posedge aclk); #1;
        bus.req_valid = '0;
        @(negedge aclk);
        checks++;
        if ({bus.rif_rd_req, bus.rif_wr_req, bus.rif_raddr} !== {1'b1, 1'b0, 12'h010}) begin
            failures++;
            $display("FAIL rd_issue: rd=%b wr=%b raddr=%h expected rd=1 wr=0 raddr=010",
                     bus.rif_rd_req, bus.rif_wr_req, bus.rif_raddr);
        end
        @(negedge aclk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== {2'b01, 32'hDEADBEEF, 1'b0}) begin
            failures++;
            $display("FAIL rd_rsp: valid=%b rdata=%h err=%b expected 01 deadbeef 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        @(negedge aclk);
        checks++;
        if (bus.rsp_valid !== 2'b00) begin
            failures++; $display("FAIL rd_rsp_pulse: valid=%b expected 00", bus.rsp_valid);
        end
    endtask

    task automatic test_write_err;
        @(posedge aclk); #1;
        bus.req_valid    = 2'b10;
        bus.req_write[1] = 1'b1;
        bus.req_addr[1]  = 12'h020;
        bus.req_wdata[1] = 32'h12345678;
        bus.req_wstrb[1] = 4'hF;
        bus.rif_wvalid   = 1'b0;
        bus.rif_rdata    = 32'hCAFEF00D;
        @(negedge aclk);
        checks++;
        if (bus.req_ready !== 2'b10) begin
            failures++; $display("FAIL wr_grant: ready=%b expected 10", bus.req_ready);
        end
        @(posedge aclk); #1;
        bus.req_valid = '0;
        @(negedge aclk);
        checks++;
        if ({bus.rif_wr_req, bus.rif_rd_req, bus.rif_waddr, bus.rif_wdata, bus.rif_wstrb} !==
            {1'b1, 1'b0, 12'h020, 32'h12345678, 4'hF}) begin
            failures++;
            $display("FAIL wr_issue: wr=%b rd=%b waddr=%h wdata=%h wstrb=%h expected 1 0 020 12345678 f",
                     bus.rif_wr_req, bus.rif_rd_req, bus.rif_waddr, bus.rif_wdata, bus.rif_wstrb);
        end
        @(negedge aclk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== {2'b10, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL wr_rsp: valid=%b rdata=%h err=%b expected 10 00000000 1",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        bus.rif_wvalid = 1'b1;
    endtask

    task automatic test_contention;
        logic [NREQ-1:0] g [0:5];
        for (int k = 0; k < 6; k++) g[k] = (k % 2 == 0) ? 2'b01 : 2'b10;
        bus.req_write    = 2'b00;
        bus.req_addr[0]  = 12'h100;
        bus.req_addr[1]  = 12'h200;
        bus.rif_rvalid   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge aclk); #1;
            bus.req_valid = (k < 6) ? 2'b11 : 2'b00;
            @(negedge aclk);
            if (k < 6) begin
                checks++;
                if (bus.req_ready !== g[k]) begin
                    failures++;
                    $display("FAIL cont_grant[%0d]: ready=%b expected %b", k, bus.req_ready, g[k]);
                end
            end
            if (k >= 1 && k <= 6) begin
                checks++;
                if ({bus.rif_rd_req, bus.rif_raddr} !== {1'b1, (g[k-1] == 2'b01) ? 12'h100 : 12'h200}) begin
                    failures++;
                    $display("FAIL cont_issue[%0d]: rd=%b raddr=%h", k, bus.rif_rd_req, bus.rif_raddr);
                end
            end
            if (k >= 2) begin
                checks++;
                if (bus.rsp_valid !== g[k-2]) begin
                    failures++;
                    $display("FAIL cont_rsp[%0d]: rsp_valid=%b expected %b", k, bus.rsp_valid, g[k-2]);
                end
            end
        end
    endtask

    task automatic test_ptr_update;
        logic [NREQ-1:0] v [0:4];
        logic [NREQ-1:0] e [0:4];
        v = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
        e = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        for (int k = 0; k < 5; k++) begin
            @(posedge aclk); #1;
            bus.req_valid = v[k];
            @(negedge aclk);
            checks++;
            if (bus.req_ready !== e[k]) begin
                failures++;
                $display("FAIL ptr_grant[%0d]: ready=%b expected %b", k, bus.req_ready, e[k]);
            end
        end
        @(posedge aclk); #1;
        bus.req_valid = '0;
        repeat (3) @(posedge aclk);
    endtask

    task automatic test_random;
        logic [NREQ-1:0] hs;
        int              viol0;
        hs    = '0;
        viol0 = stab_viol;
        for (int c = 0; c < 400; c++) begin
            @(posedge aclk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || hs[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    bus.req_write[i] = $urandom_range(0, 1) == 1;
                    bus.req_addr[i]  = AW'($urandom);
                    bus.req_wdata[i] = DW'($urandom);
                    bus.req_wstrb[i] = BW'($urandom);
                end
            end
            bus.rif_rvalid = ($urandom_range(0, 3) != 0);
            bus.rif_wvalid = ($urandom_range(0, 3) != 0);
            bus.rif_rdata  = DW'($urandom);
            @(negedge aclk);
            hs = bus.req_valid & bus.req_ready;
            checks++;
            if (bus.req_ready !== m_ready) begin
                failures++;
                $display("FAIL rnd_grant[%0d]: ready=%b expected %b", c, bus.req_ready, m_ready);
            end
            checks++;
            if ({bus.rif_wr_req, bus.rif_rd_req, bus.rif_waddr, bus.rif_raddr, bus.rif_wdata, bus.rif_wstrb} !==
                {m_iss_v & m_iss.write, m_iss_v & ~m_iss.write, m_iss.addr, m_iss.addr, m_iss.wdata,
                 (m_iss_v & m_iss.write) ? m_iss.wstrb : 4'h0}) begin
                failures++;
                $display("FAIL rnd_issue[%0d]: wr=%b rd=%b addr=%h wdata=%h wstrb=%h expected v=%b w=%b addr=%h wdata=%h wstrb=%h",
                         c, bus.rif_wr_req, bus.rif_rd_req, bus.rif_waddr, bus.rif_wdata, bus.rif_wstrb,
                         m_iss_v, m_iss.write, m_iss.addr, m_iss.wdata, m_iss.wstrb);
            end
            checks++;
            if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== {m_rsp_v, m_rsp.rdata, m_rsp.err}) begin
                failures++;
                $display("FAIL rnd_rsp[%0d]: valid=%b rdata=%h err=%b expected %b %h %b",
                         c, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, m_rsp_v, m_rsp.rdata, m_rsp.err);
            end
        end
        @(posedge aclk); #1;
        bus.req_valid = '0;
        repeat (3) @(posedge aclk);
        checks++;
        if (stab_viol !== viol0) begin
            failures++;
            $display("FAIL rnd_stability: violations=%0d expected %0d", stab_viol, viol0);
        end
    endtask

    task automatic test_reset_mid;
        @(posedge aclk); #1;
        bus.req_valid    = 2'b01;
        bus.req_write    = 2'b00;
        bus.req_addr[0]  = 12'h030;
        bus.req_addr[1]  = 12'h031;
        bus.rif_rvalid   = 1'b1;
        @(posedge aclk); #1;
        bus.req_valid = 2'b11;
        #1;
        checks++;
        if ({bus.rif_rd_req, bus.rif_raddr} !== {1'b1, 12'h030}) begin
            failures++;
            $display("FAIL rst_pre_issue: rd=%b raddr=%h expected 1 030", bus.rif_rd_req, bus.rif_raddr);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({bus.rif_rd_req, bus.rif_wr_req, bus.rif_raddr, bus.rsp_valid, bus.req_ready} !== '0) begin
            failures++;
            $display("FAIL rst_mid_clear: rd=%b wr=%b raddr=%h rsp_valid=%b ready=%b expected all 0",
                     bus.rif_rd_req, bus.rif_wr_req, bus.rif_raddr, bus.rsp_valid, bus.req_ready);
        end
        @(negedge aclk);
        checks++;
        if (bus.rsp_valid !== 2'b00) begin
            failures++; $display("FAIL rst_mid_rsp: rsp_valid=%b expected 00", bus.rsp_valid);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++; $display("FAIL rst_first_grant: ready=%b expected 01", bus.req_ready);
        end
        @(negedge aclk);
        checks++;
        if ({bus.rsp_valid, bus.rif_rd_req, bus.rif_raddr} !== {2'b00, 1'b1, 12'h030}) begin
            failures++;
            $display("FAIL rst_after: rsp_valid=%b rd=%b raddr=%h expected 00 1 030",
                     bus.rsp_valid, bus.rif_rd_req, bus.rif_raddr);
        end
        @(posedge aclk); #1;
        bus.req_valid = '0;
        repeat (3) @(posedge aclk);
    endtask

    task automatic test_stability_neg;
        int viol0;
        viol0 = stab_viol;
        @(posedge aclk); #1;
        bus.req_valid   = 2'b01;
        bus.req_addr[0] = 12'h040;
        @(posedge aclk); #1;
        bus.req_valid   = 2'b11;
        bus.req_addr[1] = 12'h050;
        @(negedge aclk);
        checks++;
        if (bus.req_ready !== 2'b10) begin
            failures++; $display("FAIL stab_setup: ready=%b expected 10", bus.req_ready);
        end
        @(posedge aclk); #1;
        bus.req_addr[0] = 12'h041;
        @(posedge aclk); #1;
        bus.req_valid = '0;
        @(posedge aclk); #1;
        checks++;
        if (stab_viol <= viol0) begin
            failures++;
            $display("FAIL stab_detect: violations=%0d expected more than %0d", stab_viol, viol0);
        end
        repeat (3) @(posedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn        = 1'b0;
        bus.req_valid  = '0;
        bus.req_write  = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.rif_wvalid = 1'b1;
        bus.rif_rvalid = 1'b1;
        bus.rif_rdata  = '0;
        test_reset();
        test_single_read();
        test_write_err();
        test_contention();
        test_ptr_update();
        test_random();
        test_reset_mid();
        test_stability_neg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
